// File: rtl/reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_sb : GPR file, 2 read + 1 write + debug port, with a        |
// |               per-register write-back scoreboard and pending count.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rf_ra0,
  input  logic [ADDR_W-1:0] rf_ra1,
  output logic [DATA_W-1:0] rf_rd0,
  output logic [DATA_W-1:0] rf_rd1,
  output logic              rf_busy0,
  output logic              rf_busy1,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_wa,
  input  logic [DATA_W-1:0] rf_wd,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_wa,
  output logic              iss_ready,
  output logic [ADDR_W:0]   pend_cnt,
  input  logic [ADDR_W-1:0] dbg_reg_ra,
  output logic [DATA_W-1:0] dbg_reg_rd
);

  localparam int          NREGS  = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic [ADDR_W:0]   r_pend_cnt;

  logic [NREGS-1:0]  w_busy_nxt;
  logic              w_set;
  logic              w_inc;
  logic              w_dec;
  logic              w_wr_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Stored value with the hardwired-zero mask; reset forces the array to 0.
  function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
    return is_zero(a) ? '0 : r_regs[a];
  endfunction

  function automatic logic fwd(input logic [ADDR_W-1:0] a);
    return (BYPASS != 0) && !rst && rf_we && (rf_wa == a) && !is_zero(a);
  endfunction

  assign w_wr_ok   = rf_we & ~is_zero(rf_wa);
  assign iss_ready = is_zero(iss_wa) | ~r_busy[iss_wa] | (rf_we & (rf_wa == iss_wa));
  assign w_set     = iss_valid & iss_ready & ~is_zero(iss_wa);
  assign w_inc     = w_set & ~r_busy[iss_wa];
  assign w_dec     = rf_we & r_busy[rf_wa] & ~(w_set & (iss_wa == rf_wa));

  assign rf_rd0     = fwd(rf_ra0) ? rf_wd : stored(rf_ra0);
  assign rf_rd1     = fwd(rf_ra1) ? rf_wd : stored(rf_ra1);
  assign rf_busy0   = r_busy[rf_ra0] & ~fwd(rf_ra0);
  assign rf_busy1   = r_busy[rf_ra1] & ~fwd(rf_ra1);
  assign dbg_reg_rd = stored(dbg_reg_ra);
  assign pend_cnt   = r_pend_cnt;

  // A new reservation outranks a completing write-back to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rf_we)
      w_busy_nxt[rf_wa] = 1'b0;
    if (w_set)
      w_busy_nxt[iss_wa] = 1'b1;
    if (ZERO_REG != 0)
      w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_inc && !w_dec)
        r_pend_cnt <= r_pend_cnt + c_ONE;
      else if (w_dec && !w_inc)
        r_pend_cnt <= r_pend_cnt - c_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[rf_wa] <= rf_wd;
    end
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file with an integrated write-back scoreboard, intended for the pipelined RISC-V core.
- Provides two combinational read ports, one synchronous write port, and a debug read port.
- Optional same-cycle write-to-read bypass.
- Per-register busy tracking lets decode detect RAW hazards and block WAW issue.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W.
- BYPASS, 1, 1 = read ports forward rf_wd on same-cycle address match; 0 = read ports return stored value only.
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- rf_ra0  in  ADDR_W  read address 0.
- rf_ra1  in  ADDR_W  read address 1.
- rf_rd0  out  DATA_W  read data 0, combinational.
- rf_rd1  out  DATA_W  read data 1, combinational.
- rf_busy0  out  1  register rf_ra0 has a pending producer.
- rf_busy1  out  1  register rf_ra1 has a pending producer.
- rf_we  in  1  write-back enable.
- rf_wa  in  ADDR_W  write-back address.
- rf_wd  in  DATA_W  write-back data.
- iss_valid  in  1  issue of an instruction that will write iss_wa.
- iss_wa  in  ADDR_W  destination register being reserved.
- iss_ready  out  1  reservation of iss_wa accepted this cycle.
- pend_cnt  out  ADDR_W+1  number of registers currently busy.
- dbg_reg_ra  in  ADDR_W  debug read address.
- dbg_reg_rd  out  DATA_W  debug read data; stored value, never bypassed.

Behaviour:
- Reset (rst high, asynchronous, dominates clk):
  - all NREGS registers = 0; all busy bits = 0; pend_cnt = 0.
  - Read outputs therefore show 0 and busy flags 0 while rst is high.
  - Reset mid-operation discards all pending reservations; no write-back is performed in a reset cycle.
- Zero-register handling: "reg 0 is zero" means ZERO_REG=1 and the address equals 0.
- Write:
  - On posedge with rf_we=1, reg[rf_wa] <= rf_wd.
  - If reg 0 is zero, the write is dropped.
  - Write latency is 1 cycle: the stored value is visible on all read ports from the next cycle.
- Read:
  - rf_rdN = reg[rf_raN].
  - If BYPASS=1, rf_we=1, rf_wa==rf_raN and the address is not a hardwired zero, then rf_rdN = rf_wd in the same cycle.
  - Reg 0 always reads 0 when ZERO_REG=1.
  - Both ports may address the same register.
- Busy bits: one per register, busy[0] is constant 0 when ZERO_REG=1.
  - iss_ready = (iss_wa is hardwired zero) | ~busy[iss_wa] | (rf_we & rf_wa==iss_wa). A reservation is blocked only while an earlier producer of the same register is outstanding (WAW).
  - iss_ready is combinational and does not depend on iss_valid.
  - Set: iss_valid & iss_ready & ~(iss_wa hardwired zero) sets busy[iss_wa] at posedge.
  - Clear: rf_we clears busy[rf_wa] at posedge.
  - Simultaneous set and clear of the same register: set wins, busy stays 1 (new producer replaces the completing one).
  - A write to a non-busy register is legal; busy stays 0.
- rf_busyN:
  - BYPASS=1: busy[rf_raN] & ~(rf_we & rf_wa==rf_raN), i.e. the value arriving this cycle is forwarded and does not stall.
  - BYPASS=0: busy[rf_raN].
- pend_cnt: registered counter, equals the population count of the busy bits at all times.
  - +1 when a set occurs on a non-busy register.
  - -1 when a clear hits a busy register and no set of that register occurs the same cycle.
  - Net 0 when a set and a clear of different registers happen together.
  - Net 0 when a set and a clear hit the same busy register.
  - Maximum NREGS-1 with ZERO_REG=1, NREGS otherwise; never wraps.
- Debug port: dbg_reg_rd = reg[dbg_reg_ra], combinational, no bypass, no effect on state.

Test Plan:
- Reset: write 0xDEADBEEF to x5, assert rst asynchronously mid-cycle → rf_rd0 for ra0=5 reads 0, pend_cnt=0, all busy=0 before the next edge.
- x0 protection (ZERO_REG=1): rf_we=1, wa=0, wd=0x12345678, plus iss_valid with iss_wa=0 → x0 reads 0, iss_ready=1, pend_cnt unchanged.
- Bypass: with BYPASS=1 and x7=0x11, drive rf_we=1, wa=7, wd=0x22, ra0=ra1=7 → same cycle rf_rd0=rf_rd1=0x22, dbg_reg_rd=0x11; next cycle dbg_reg_rd=0x22. With BYPASS=0, the same stimulus gives rf_rd0=0x11 in that cycle.
- Scoreboard RAW: issue x3 → next cycle rf_busy0=1 for ra0=3, pend_cnt=1. Write-back x3=0x55 → rf_busy0=0 in the write cycle (BYPASS=1), rf_rd0=0x55, pend_cnt=0 next cycle.
- WAW/simultaneous: x9 busy, iss_wa=9 without write → iss_ready=0. Same cycle rf_we wa=9 and iss_valid iss_wa=9 → iss_ready=1, busy[9] remains 1, pend_cnt stays 1.
- Counter saturation: issue x1..x31 back-to-back → pend_cnt=31, each iss_ready=1. Write back x1..x31 in any order → pend_cnt decrements to 0 with no wrap.
